// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - byte-to-serial UART framer (8N1/8N2) paced by an external baud square wave
// One-byte holding register in front of a start/data/stop shifter; all timing comes from baud_clk rising edges.
module uart_tx_framer #(
  parameter int STOP_BITS = 1
) (
  input  logic       clk_50M,
  input  logic       rst,
  input  logic       baud_clk,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  state_t      state;
  logic        sync1;
  logic        sync2;
  logic        prev;
  logic [1:0]  settle;
  logic        baud_tick;
  logic        accept;
  logic [7:0]  hold;
  logic        hold_full;
  logic [7:0]  shift;
  logic [2:0]  bit_cnt;
  logic        stop_cnt;

  assign baud_tick = sync2 & ~prev;
  assign accept    = tx_valid & tx_ready;

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      prev      <= 1'b1;
      settle    <= 2'b00;
      hold      <= 8'h00;
      hold_full <= 1'b0;
      shift     <= 8'h00;
      bit_cnt   <= 3'd0;
      stop_cnt  <= 1'b0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      tx_ready  <= 1'b1;
    end else begin
      sync1  <= baud_clk;
      sync2  <= sync1;
      // prev stays high until sync2 carries a post-reset sample, so a level
      // that was already high at release never looks like a rising edge
      settle <= {settle[0], 1'b1};
      prev   <= settle[1] ? sync2 : 1'b1;

      if (accept) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
        tx_ready  <= 1'b0;
      end

      if (baud_tick) begin
        case (state)
          IDLE: begin
            if (hold_full) begin
              tx        <= 1'b0;
              shift     <= hold;
              hold_full <= 1'b0;
              tx_ready  <= 1'b1;
              busy      <= 1'b1;
              state     <= START;
            end else begin
              tx <= 1'b1;
            end
          end
          START: begin
            tx      <= shift[0];
            bit_cnt <= 3'd0;
            state   <= DATA;
          end
          DATA: begin
            if (bit_cnt != 3'd7) begin
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
              bit_cnt <= bit_cnt + 3'd1;
            end else begin
              tx       <= 1'b1;
              stop_cnt <= 1'b0;
              state    <= STOP;
            end
          end
          STOP: begin
            if (stop_cnt != STOP_LAST) begin
              stop_cnt <= 1'b1;
            end else if (hold_full) begin
              // chain straight into the next start bit with no idle gap
              tx        <= 1'b0;
              shift     <= hold;
              hold_full <= 1'b0;
              tx_ready  <= 1'b1;
              state     <= START;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb/tb_uart_tx_framer.sv - self-checking bench for uart_tx_framer
// Expected serial bits are queued when a byte is presented and compared mid-bit on baud_clk falling edges.
module tb_uart_tx_framer;

  logic       clk_50M;
  logic       rst;
  logic       baud_clk;
  logic       baud_run;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       busy;
  logic [7:0] tx_data2;
  logic       tx_valid2;
  logic       tx_ready2;
  logic       tx2;
  logic       busy2;

  int   n_cmp;
  int   n_bad;
  int   tx_edges;
  logic sb[$];
  logic mon_active;
  logic mon_exp;

  uart_tx_framer #(.STOP_BITS(1)) dut (
    .clk_50M (clk_50M),
    .rst     (rst),
    .baud_clk(baud_clk),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx      (tx),
    .busy    (busy)
  );

  uart_tx_framer #(.STOP_BITS(2)) dut2 (
    .clk_50M (clk_50M),
    .rst     (rst),
    .baud_clk(baud_clk),
    .tx_data (tx_data2),
    .tx_valid(tx_valid2),
    .tx_ready(tx_ready2),
    .tx      (tx2),
    .busy    (busy2)
  );

  initial begin
    clk_50M = 1'b0;
    forever #10 clk_50M = ~clk_50M;
  end

  initial begin
    baud_clk = 1'b0;
    #3;
    forever begin
      #4340;
      if (baud_run) baud_clk = ~baud_clk;
    end
  end

  always @(tx) tx_edges = tx_edges + 1;

  always @(negedge tx) begin
    if (!mon_active && sb.size() > 0) mon_active = 1'b1;
  end

  always @(negedge baud_clk) begin
    if (mon_active && sb.size() > 0) begin
      mon_exp = sb.pop_front();
      n_cmp = n_cmp + 1;
      if (tx !== mon_exp) begin
        n_bad = n_bad + 1;
        $display("FAIL serial_bit t=%0t got %0b want %0b", $time, tx, mon_exp);
      end
      if (sb.size() == 0) mon_active = 1'b0;
    end
  end

  task automatic present(input logic [7:0] d);
    int t;
    t = 0;
    while (tx_ready !== 1'b1 && t < 2000) begin
      @(negedge clk_50M);
      t++;
    end
    if (t >= 2000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL present_timeout tx_ready=%0b want 1", tx_ready);
    end else begin
      @(negedge clk_50M);
      tx_data  = d;
      tx_valid = 1'b1;
      @(posedge clk_50M);
      #1;
      tx_valid = 1'b0;
      sb.push_back(1'b0);
      for (int i = 0; i < 8; i++) sb.push_back(d[i]);
      sb.push_back(1'b1);
    end
  endtask

  task automatic wait_tx_fall(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk_50M);
      #1;
      if (tx === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL tx_fall_timeout tx=%0b want 0", tx);
    end
  endtask

  task automatic wait_empty(input int lim);
    int t;
    t = 0;
    while (sb.size() != 0 && t < lim) begin
      @(posedge clk_50M);
      t++;
    end
    #1;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout pending=%0d want 0", sb.size());
      sb.delete();
      mon_active = 1'b0;
    end
  endtask

  task automatic gap();
    repeat (500) @(posedge clk_50M);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk_50M);
    #3;
    rst = 1'b1;
    sb.delete();
    mon_active = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk_50M);
    @(negedge clk_50M);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #5;
    n_cmp += 4;
    if (tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx got %0b want 1", tx); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0b want 0", busy); end
    if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %0b want 1", tx_ready); end
    if (tx2 !== 1'b1) begin n_bad++; $display("FAIL reset_tx2 got %0b want 1", tx2); end
    release_reset();
    repeat (1000) @(posedge clk_50M);
    #1;
    n_cmp += 2;
    if (tx !== 1'b1) begin n_bad++; $display("FAIL idle_tx got %0b want 1", tx); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy got %0b want 0", busy); end
  endtask

  task automatic test_basic();
    bit ok;
    int lo;
    int bcnt;
    present(8'h53);
    n_cmp++;
    if (tx_ready !== 1'b0) begin n_bad++; $display("FAIL accept_ready_drop got %0b want 0", tx_ready); end
    wait_tx_fall(ok);
    if (ok) begin
      n_cmp++;
      if (busy !== 1'b1) begin n_bad++; $display("FAIL start_busy got %0b want 1", busy); end
      lo = 1;
      bcnt = 1;
      while (tx === 1'b0 && lo < 2000) begin
        @(posedge clk_50M);
        #1;
        if (tx === 1'b0) lo++;
        if (busy === 1'b1) bcnt++;
      end
      while (busy === 1'b1 && bcnt < 6000) begin
        @(posedge clk_50M);
        #1;
        if (busy === 1'b1) bcnt++;
      end
      n_cmp += 3;
      if (lo != 434) begin n_bad++; $display("FAIL start_bit_len got %0d want 434", lo); end
      if (bcnt != 4340) begin n_bad++; $display("FAIL busy_len got %0d want 4340", bcnt); end
      if (tx !== 1'b1) begin n_bad++; $display("FAIL end_tx got %0b want 1", tx); end
    end
    wait_empty(2000);
    gap();
  endtask

  task automatic test_back_to_back();
    bit ok;
    present(8'h53);
    wait_tx_fall(ok);
    repeat (868) @(posedge clk_50M);
    #1;
    n_cmp++;
    if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready got %0b want 1", tx_ready); end
    present(8'h4D);
    wait_empty(12000);
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_stop_busy got %0b want 1", busy); end
    gap();
  endtask

  task automatic test_hold();
    int ready_hi;
    present(8'h11);
    present(8'h3C);
    ready_hi = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_50M);
      tx_data  = 8'($urandom);
      tx_valid = 1'b1;
      if (tx_ready !== 1'b0) ready_hi++;
    end
    @(negedge clk_50M);
    tx_valid = 1'b0;
    n_cmp++;
    if (ready_hi != 0) begin n_bad++; $display("FAIL hold_ready_low got %0d high cycles want 0", ready_hi); end
    wait_empty(12000);
    gap();
    n_cmp += 2;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL hold_extra_frame busy=%0b want 0", busy); end
    if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL hold_final_ready got %0b want 1", tx_ready); end
  endtask

  task automatic test_two_stop();
    int t;
    int run;
    int lo;
    int cnt;
    @(negedge clk_50M);
    tx_data2  = 8'hFF;
    tx_valid2 = 1'b1;
    @(posedge clk_50M);
    #1;
    tx_valid2 = 1'b0;
    t = 0;
    while (tx2 !== 1'b0 && t < 1500) begin
      @(posedge clk_50M);
      #1;
      t++;
    end
    n_cmp++;
    if (tx2 !== 1'b0) begin
      n_bad++;
      $display("FAIL stop2_start_timeout tx2=%0b want 0", tx2);
    end else begin
      run = 1;
      lo = 1;
      cnt = 1;
      while (tx2 === 1'b0 && cnt < 6000) begin
        @(posedge clk_50M);
        #1;
        if (tx2 === 1'b0) begin run++; lo++; end
        if (busy2 === 1'b1) cnt++;
      end
      while (busy2 === 1'b1 && cnt < 6000) begin
        @(posedge clk_50M);
        #1;
        if (busy2 === 1'b1) cnt++;
        if (tx2 === 1'b0) lo++;
      end
      n_cmp += 3;
      if (run != 434) begin n_bad++; $display("FAIL stop2_start_len got %0d want 434", run); end
      if (lo != 434) begin n_bad++; $display("FAIL stop2_low_total got %0d want 434", lo); end
      if (cnt != 4774) begin n_bad++; $display("FAIL stop2_busy_len got %0d want 4774", cnt); end
    end
    gap();
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int e0;
    present(8'hA5);
    wait_tx_fall(ok);
    repeat (434 * 5 + 200) @(posedge clk_50M);
    present(8'h0F);
    pulse_reset();
    n_cmp += 3;
    if (tx !== 1'b1) begin n_bad++; $display("FAIL abort_tx got %0b want 1", tx); end
    if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL abort_ready got %0b want 1", tx_ready); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %0b want 0", busy); end
    release_reset();
    e0 = tx_edges;
    repeat (1302) @(posedge clk_50M);
    #1;
    n_cmp += 2;
    if (tx_edges != e0) begin n_bad++; $display("FAIL abort_quiet got %0d edges want 0", tx_edges - e0); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_held_byte busy=%0b want 0", busy); end
    present(8'h5A);
    wait_empty(6000);
    gap();
  endtask

  task automatic test_baud_stuck();
    int e0;
    int late;
    @(posedge baud_clk);
    baud_run = 1'b0;
    pulse_reset();
    release_reset();
    present(8'h96);
    e0 = tx_edges;
    repeat (1500) @(posedge clk_50M);
    #1;
    n_cmp += 3;
    if (tx_edges != e0) begin n_bad++; $display("FAIL stuck_quiet got %0d edges want 0", tx_edges - e0); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL stuck_busy got %0b want 0", busy); end
    if (tx_ready !== 1'b0) begin n_bad++; $display("FAIL stuck_held got ready=%0b want 0", tx_ready); end
    baud_run = 1'b1;
    @(posedge baud_clk);
    late = 0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk_50M);
      #1;
      if (tx !== 1'b1) late++;
    end
    @(posedge clk_50M);
    #1;
    n_cmp += 2;
    if (late != 0) begin n_bad++; $display("FAIL tick_early got %0d low samples want 0", late); end
    if (tx !== 1'b0) begin n_bad++; $display("FAIL tick_third_edge tx=%0b want 0", tx); end
    wait_empty(6000);
    gap();
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    tx_edges   = 0;
    mon_active = 1'b0;
    mon_exp    = 1'b0;
    baud_run   = 1'b1;
    rst        = 1'b1;
    tx_data    = 8'h00;
    tx_valid   = 1'b0;
    tx_data2   = 8'h00;
    tx_valid2  = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_hold();
    test_two_stop();
    test_reset_mid_frame();
    test_baud_stuck();
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL scoreboard_left got %0d want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 The block SHALL have parameter STOP_BITS, default 1, number of stop bits per frame (legal values 1 or 2).
REQ-002 The block SHALL have port clk_50M  input  1  system clock, 50 MHz, all state on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have port baud_clk  input  1  bit-rate square wave from the baud divider (period 434 clk_50M cycles), asynchronous to the flops.
REQ-005 The block SHALL have port tx_data  input  8  byte to transmit, sampled on accept.
REQ-006 The block SHALL have port tx_valid  input  1  tx_data is valid.
REQ-007 The block SHALL have port tx_ready  output  1  holding register empty; a byte is accepted when tx_valid and tx_ready are both high on a clk_50M edge.
REQ-008 The block SHALL have port tx  output  1  serial line, 8N1 (or 8N2) format, LSB first, idle high, registered.
REQ-009 The block SHALL have port busy  output  1  high whenever the FSM is not IDLE, registered.

Function
REQ-010 baud_clk SHALL pass through a two-flop synchroniser (sync1, sync2), followed by a previous-value flop (prev).
REQ-011 The internal baud_tick SHALL equal sync2 AND NOT prev, so it is one clk_50M cycle wide per baud_clk rising edge.
REQ-012 Every tx/FSM update driven by a tick SHALL occur on the 3rd clk_50M rising edge after the baud_clk rising edge, and SHALL be held exactly one tick interval.
REQ-013 The holding register SHALL hold one byte; tx_ready SHALL be NOT hold_full, registered.
REQ-014 On accept, the holding register SHALL load tx_data and set hold_full on the same edge, so tx_ready is low in the following cycle.
REQ-015 tx_valid while tx_ready is low SHALL be ignored; the held byte SHALL NOT be overwritten.
REQ-016 The FSM SHALL have states IDLE, START, DATA and STOP; all transitions SHALL occur only on cycles where baud_tick is high.
REQ-017 IDLE with hold_full: tx<=0, shift<=hold, hold_full<=0, next state START.
REQ-018 IDLE without hold_full: the FSM SHALL stay in IDLE with tx=1.
REQ-019 START: tx<=shift[0], bit_cnt<=0, next state DATA.
REQ-020 DATA with bit_cnt<7: shift right, tx<=next bit, bit_cnt+1.
REQ-021 DATA with bit_cnt==7: tx<=1, stop_cnt<=0, next state STOP.
REQ-022 STOP with stop_cnt<STOP_BITS-1: stop_cnt+1, tx stays 1.
REQ-023 STOP with final stop bit, hold_full: tx<=0, load the held byte, next state START (back-to-back, no idle gap).
REQ-024 STOP with final stop bit, hold not full: tx stays 1, next state IDLE.
REQ-025 bit_cnt SHALL be 3 bits and stop_cnt 1 bit; neither counter SHALL ever wrap.
REQ-026 An accept and a hold unload SHALL never coincide, because tx_ready is low while hold_full; no arbitration is needed.
REQ-027 A byte accepted mid-frame SHALL wait in the holding register; the frame in flight SHALL be unaffected.
REQ-028 baud_clk stuck high or stuck low SHALL generate no ticks and SHALL freeze the FSM with tx holding its current value.

Reset
REQ-029 rst high SHALL asynchronously force tx=1, busy=0, tx_ready=1, state=IDLE, hold_full=0, shift=0, bit_cnt=0, stop_cnt=0, sync1=sync2=0, prev=1.
REQ-030 prev resetting to 1 SHALL suppress a spurious tick at reset release.
REQ-031 rst asserted mid-frame SHALL abort the frame, return tx high within the same cycle, and discard any held byte.
REQ-032 The first tick after reset release SHALL require a genuine baud_clk rising edge observed after release.

Verification
REQ-033 Reset, then tx_valid=1 with tx_data=0x53 for one cycle -> tx_ready drops next cycle; tx = 0,1,1,0,0,1,0,1,0,1, each bit 434 cycles; busy high from start bit through stop bit.
REQ-034 Accept 0x53, then accept 0x4D during the first frame's data bits -> second start bit immediately follows the first stop bit; second frame data = 1,0,1,1,0,0,1,0; no idle gap.
REQ-035 tx_valid held high with tx_data changing while tx_ready=0 -> only the first presented byte is transmitted; the held byte is unchanged.
REQ-036 STOP_BITS=2, send 0xFF -> tx low for 434 cycles, then high for 434*10 cycles; busy falls only after the second stop bit.
REQ-037 rst pulsed during data bit 4 of 0xA5 -> tx=1 and tx_ready=1 immediately; no further toggling until a new byte is accepted.
REQ-038 baud_clk held high across reset release -> no tick and tx stays 1; the first frame starts only after the next baud_clk rising edge.
